// File: rtl/regq_ctrl_pkg.sv
// regq_ctrl_pkg
// Common types for the register-queue controller. The queue operation
// decode is shared by anything that tracks occupancy.
package regq_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } q_op_t;

    function automatic q_op_t op_decode(input logic push_fire, input logic pop_fire);
        return q_op_t'({pop_fire, push_fire});
    endfunction

endpackage

// File: rtl/onehot_ptr.sv
// onehot_ptr
// DEPTH-wide one-hot rotating pointer with a wrap-phase bit. The phase
// toggles each time the set bit rotates from the top position back to bit 0,
// which lets equal pointers be told apart as empty versus full.
// Ports:
//   clk  - rising-edge clock
//   clr  - synchronous clear, active-high (pointer to bit 0, phase to 0)
//   adv  - rotate left by one this cycle
//   ptr  - current one-hot pointer
//   ph   - current wrap phase
`include "regq_defs.vh"

module onehot_ptr #(
    parameter int DEPTH = `REGQ_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             adv,
    output logic [DEPTH-1:0] ptr,
    output logic             ph
);

    logic [DEPTH-1:0] ptr_reg, ptr_next;
    logic             ph_reg, ph_next;

    always_comb begin
        ptr_next = ptr_reg;
        ph_next  = ph_reg;
        if (adv) begin
            ptr_next = {ptr_reg[DEPTH-2:0], ptr_reg[DEPTH-1]};
            // Wrapping out of the top entry flips the lap parity.
            ph_next  = ph_reg ^ ptr_reg[DEPTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            ptr_reg <= `REGQ_PTR_RST(DEPTH);
            ph_reg  <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
            ph_reg  <= ph_next;
        end
    end

    assign ptr = ptr_reg;
    assign ph  = ph_reg;

endmodule

// File: rtl/regq_defs.vh
// regq_defs.vh
// Shared defaults for the register-queue controller: parameter defaults,
// the one-hot pointer reset value and the occupancy counter width.
`ifndef REGQ_DEFS_VH
`define REGQ_DEFS_VH

`define REGQ_DEPTH_DEFAULT     4
`define REGQ_AF_THRESH_DEFAULT 1

// One-hot pointer reset value: bit 0 set, all others clear.
`define REGQ_PTR_RST(d) {{((d)-1){1'b0}}, 1'b1}

// Width needed to count 0..d entries inclusive.
`define REGQ_OCC_W(d) $clog2((d) + 1)

`endif

// File: rtl/regq_ctrl.sv
// regq_ctrl
// Sequences a bank of DEPTH external load/clear registers as a circular
// FIFO. Entry data lives outside; this block owns the one-hot write/read
// pointers, drives per-entry load strobes and the read-mux select, and
// presents valid/ready handshakes.
// Optional occupancy counter and almost_full flag: define REGQ_CTRL_OCC_EN.
// Ports:
//   clk         - rising-edge clock
//   clr         - synchronous reset, active-high (highest priority)
//   flush       - synchronous discard of all entries
//   push_valid  - producer offers an entry
//   push_ready  - an entry can be accepted (not full)
//   pop_ready   - consumer takes the head entry
//   pop_valid   - head entry is valid (not empty)
//   wr_ld       - one-hot load strobe to the entry registers
//   rd_sel      - one-hot head select for the external read mux
//   empty/full  - status flags
//   occ         - occupancy count (REGQ_CTRL_OCC_EN only)
//   almost_full - free entries <= AF_THRESH (REGQ_CTRL_OCC_EN only)
`include "regq_defs.vh"

module regq_ctrl
    import regq_ctrl_pkg::*;
#(
    parameter int DEPTH     = `REGQ_DEPTH_DEFAULT,
    parameter int AF_THRESH = `REGQ_AF_THRESH_DEFAULT
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic                           flush,
    input  logic                           push_valid,
    output logic                           push_ready,
    input  logic                           pop_ready,
    output logic                           pop_valid,
    output logic [DEPTH-1:0]               wr_ld,
    output logic [DEPTH-1:0]               rd_sel,
    output logic                           empty,
`ifdef REGQ_CTRL_OCC_EN
    output logic                           full,
    output logic [`REGQ_OCC_W(DEPTH)-1:0]  occ,
    output logic                           almost_full
`else
    output logic                           full
`endif
);

    logic [DEPTH-1:0] wr_ptr, rd_ptr;
    logic             wr_ph, rd_ph;
    logic             ptr_eq;
    logic             push_fire, pop_fire;
    logic             discard;

    // Flush has the same register effect as clr; both block any fire.
    assign discard = clr | flush;

    onehot_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .clr (discard),
        .adv (push_fire),
        .ptr (wr_ptr),
        .ph  (wr_ph)
    );

    onehot_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .clr (discard),
        .adv (pop_fire),
        .ptr (rd_ptr),
        .ph  (rd_ph)
    );

    // Status decodes from registered state only, so ready/valid have no
    // combinational path from any input.
    assign ptr_eq     = (wr_ptr == rd_ptr);
    assign empty      = ptr_eq & (wr_ph == rd_ph);
    assign full       = ptr_eq & (wr_ph != rd_ph);
    assign push_ready = ~full;
    assign pop_valid  = ~empty;

    assign push_fire = push_valid & push_ready & ~discard;
    assign pop_fire  = pop_valid & pop_ready & ~discard;

    // The entry register loads on the same edge the write pointer advances.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_ld
        assign wr_ld[gi] = wr_ptr[gi] & push_fire;
    end

    assign rd_sel = rd_ptr;

`ifdef REGQ_CTRL_OCC_EN
    localparam int OCC_W = `REGQ_OCC_W(DEPTH);

    logic [OCC_W-1:0] occ_reg, occ_next;

    always_comb begin
        occ_next = occ_reg;
        unique case (op_decode(push_fire, pop_fire))
            OP_PUSH: occ_next = occ_reg + 1'b1;
            OP_POP:  occ_next = occ_reg - 1'b1;
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (discard) begin
            occ_reg <= '0;
        end else begin
            occ_reg <= occ_next;
        end
    end

    assign occ         = occ_reg;
    assign almost_full = ((DEPTH - int'(occ_reg)) <= AF_THRESH);
`endif

endmodule

// File: tb/tb_regq_ctrl.sv
// tb_regq_ctrl
// Self-checking bench for regq_ctrl at DEPTH=4. A reference model tracks
// slot indices and occupancy; each accepted push queues its slot index and
// each accepted pop compares the DUT's read select with the queued slot.
`timescale 1ns/1ps

module tb_regq_ctrl;

    localparam int D  = 4;
    localparam int AF = 1;

    logic         clk = 1'b0;
    logic         clr, flush, push_valid, pop_ready;
    logic         push_ready, pop_valid, empty, full;
    logic [D-1:0] wr_ld, rd_sel;
`ifdef REGQ_CTRL_OCC_EN
    logic [$clog2(D+1)-1:0] occ;
    logic                   almost_full;
`endif

    regq_ctrl #(.DEPTH(D), .AF_THRESH(AF)) dut (
        .clk         (clk),
        .clr         (clr),
        .flush       (flush),
        .push_valid  (push_valid),
        .push_ready  (push_ready),
        .pop_ready   (pop_ready),
        .pop_valid   (pop_valid),
        .wr_ld       (wr_ld),
        .rd_sel      (rd_sel),
        .empty       (empty),
`ifdef REGQ_CTRL_OCC_EN
        .full        (full),
        .occ         (occ),
        .almost_full (almost_full)
`else
        .full        (full)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    int m_wr = 0;
    int m_rd = 0;
    int m_cnt = 0;
    int sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [D-1:0] oh(input int idx);
        logic [D-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // One clock of stimulus: drive, check combinational outputs, clock, update model.
    task automatic step(input logic pv, input logic pr, input logic fl, input logic cl);
        logic         pf, qf;
        logic [D-1:0] exp_ld;
        int           slot;
        push_valid = pv;
        pop_ready  = pr;
        flush      = fl;
        clr        = cl;
        #1;
        pf = pv && (m_cnt < D) && !fl && !cl;
        qf = pr && (m_cnt > 0) && !fl && !cl;
        exp_ld = pf ? oh(m_wr) : '0;
        check("empty",      32'(empty),      32'(m_cnt == 0));
        check("full",       32'(full),       32'(m_cnt == D));
        check("push_ready", 32'(push_ready), 32'(m_cnt != D));
        check("pop_valid",  32'(pop_valid),  32'(m_cnt != 0));
        check("rd_sel",     32'(rd_sel),     32'(oh(m_rd)));
        check("rd_onehot",  32'($onehot(rd_sel)), 32'd1);
        check("wr_ld",      32'(wr_ld),      32'(exp_ld));
`ifdef REGQ_CTRL_OCC_EN
        check("occ",         32'(occ),         32'(m_cnt));
        check("almost_full", 32'(almost_full), 32'((D - m_cnt) <= AF));
`endif
        if (qf) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                slot = sb_q.pop_front();
                check("pop_slot", 32'(rd_sel), 32'(oh(slot)));
            end
        end
        $display("cyc %0d pv=%b pr=%b fl=%b clr=%b wr_ld=%b rd_sel=%b e=%b f=%b",
                 cyc, pv, pr, fl, cl, wr_ld, rd_sel, empty, full);
        @(posedge clk);
        cyc++;
        if (cl || fl) begin
            m_wr = 0;
            m_rd = 0;
            m_cnt = 0;
            sb_q.delete();
        end else begin
            if (pf) begin
                sb_q.push_back(m_wr);
                m_wr = (m_wr + 1) % D;
            end
            if (qf) m_rd = (m_rd + 1) % D;
            m_cnt = m_cnt + (pf ? 1 : 0) - (qf ? 1 : 0);
        end
        @(negedge clk);
    endtask

    initial begin
        clr = 1'b1;
        flush = 1'b0;
        push_valid = 1'b0;
        pop_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        step(0, 0, 0, 0);

        // Fill, then a fifth push is refused
        repeat (4) step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        // Drain with wrap, then idle at empty
        repeat (4) step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // Two queued, then simultaneous push/pop past the wrap
        repeat (2) step(1, 0, 0, 0);
        repeat (6) step(1, 1, 0, 0);
        repeat (2) step(0, 1, 0, 0);

        // Push+pop while empty: only the push happens
        step(1, 1, 0, 0);
        // Fill to full, then push+pop while full: only the pop happens
        repeat (3) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);

        // Flush mid-operation with a push offered
        step(0, 0, 0, 1);
        repeat (3) step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        step(0, 0, 0, 0);

        // clr and flush together
        repeat (3) step(1, 0, 0, 0);
        step(1, 0, 1, 1);
        step(0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 63) == 0));
        end
        step(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regq_ctrl.md
Name: regq_ctrl

Overview:
- Controller that sequences a bank of DEPTH external n-bit load/clear registers as a circular FIFO.
- Owns one-hot write and read pointers, generates per-entry load strobes and the one-hot read-select for the external output mux, and presents valid/ready handshakes to producer and consumer.
- Sits between a producer stage and a consumer stage in the pipeline's queue structures. Entry data storage stays outside the block.

Parameters:
- DEPTH, 4, number of register entries; legal range 2..32, any integer.
- AF_THRESH, 1, free-entry count at or below which almost_full asserts (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- clr  input  1  synchronous reset, active-high.
- flush  input  1  synchronous queue discard, active-high.
- push_valid  input  1  producer offers an entry.
- push_ready  output  1  controller can accept a push this cycle.
- pop_ready  input  1  consumer takes the head entry.
- pop_valid  output  1  head entry is valid.
- wr_ld  output  DEPTH  one-hot load strobe to entry registers (drive each entry's ld).
- rd_sel  output  DEPTH  one-hot head-entry select for the external read mux.
- empty  output  1  queue holds no entries.
- full  output  1  queue holds DEPTH entries.
- occ  output  $clog2(DEPTH+1)  occupancy (optional feature only).
- almost_full  output  1  free entries <= AF_THRESH (optional feature only).

Behaviour:
- Clock and reset: one clock; clr is synchronous, active-high, sampled on the rising edge of clk.
- State:
  - wr_ptr[DEPTH] and rd_ptr[DEPTH], one-hot.
  - wr_ph and rd_ph, 1-bit wrap phases.
  - All registered on clk.
- Reset (clr=1 at edge): wr_ptr = rd_ptr = 1 (bit 0 set), wr_ph = rd_ph = 0.
- Outputs after reset: empty=1, full=0, push_ready=1, pop_valid=0, rd_sel=1, wr_ld=0.
- clr has priority over flush, push and pop. clr asserted mid-operation discards all entries at that edge.
- flush=1 (clr=0): same register effect as clr at the edge. During the flush cycle push is not accepted and wr_ld=0, even though push_ready stays combinational.
- Status decode:
  - empty = (wr_ptr==rd_ptr) & (wr_ph==rd_ph).
  - full = (wr_ptr==rd_ptr) & (wr_ph!=rd_ph).
- Handshake outputs:
  - push_ready = !full.
  - pop_valid = !empty.
  - Both are combinational from registered state only; no input-to-output path into ready or valid.
- push_fire = push_valid & push_ready & !flush & !clr.
- pop_fire = pop_valid & pop_ready & !flush & !clr.
- wr_ld = wr_ptr when push_fire, else all zeros; combinational. The entry loads at the same edge the pointer advances, so write latency is 1 cycle.
- rd_sel = rd_ptr at all times. Data is visible to the consumer the cycle after the entry's wr_ld edge (1-cycle push-to-pop latency, no bypass).
- Pointer advance: rotate left by one on fire. When bit DEPTH-1 rotates to bit 0, toggle the matching phase bit.
- Simultaneous push_fire and pop_fire: both pointers advance and occupancy is unchanged.
  - When full: push_ready=0, so only the pop takes effect.
  - When empty: pop_valid=0, so only the push takes effect.
- Driving pop_ready while empty, or push_valid while full, has no effect and is not an error.
- Pointer invariant: each pointer holds exactly one bit set after any sequence. The bench asserts this every cycle.

Optional Feature:
- Macro: REGQ_CTRL_OCC_EN.
- Defined:
  - Registered occ counter: 0 on clr/flush; +1 on push-only; -1 on pop-only; unchanged on both or neither.
  - almost_full = (DEPTH - occ) <= AF_THRESH, combinational from occ.
- Undefined:
  - occ and almost_full ports are absent.
  - No counter logic is instantiated.
  - All other behaviour is identical.

Decomposition:
- Shared header regq_defs.vh holds:
  - default DEPTH and AF_THRESH values;
  - the pointer reset value (one-hot bit 0);
  - an occupancy-width macro derived from DEPTH.
- One sub-module, onehot_ptr:
  - a DEPTH-wide one-hot rotating pointer with wrap phase;
  - inputs adv, clr; outputs ptr, ph;
  - instantiated twice, for write and read.

Test Plan (DEPTH=4):
- Reset: hold clr 2 cycles -> wr_ld=0000, rd_sel=0001, empty=1, full=0, push_ready=1, pop_valid=0.
- Fill: push_valid=1 for 4 cycles -> wr_ld = 0001, 0010, 0100, 1000. Then full=1, push_ready=0; a 5th push yields wr_ld=0000.
- Drain with wrap: after fill, pop_ready=1 for 4 cycles -> rd_sel = 0001, 0010, 0100, 1000, then back to 0001 with empty=1 and pointers/phases equal.
- Simultaneous: with 2 entries queued, push and pop for 6 cycles -> full and empty stay 0, rd_sel walks and wraps past 1000, occ stays 2 (feature on).
- Boundaries: push+pop while empty -> only the push occurs (pop_valid=0). Push+pop while full -> only the pop occurs, full deasserts next cycle.
- Flush/clr mid-operation: with 3 entries, assert flush with push_valid=1 -> wr_ld=0000 that cycle, next cycle empty=1, rd_sel=0001. Repeat with clr=1 and flush=1 together -> identical result.
